// File: rtl/seq_detect_prog_pkg.sv
// Shared types and default sizing for the programmable serial sequence detector.
package seq_detect_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        ARMED = 2'd1,
        ERR   = 2'd2
    } state_t;

endpackage

// File: rtl/seq_detect_prog_if.sv
// Configuration, serial data and status bundle of the sequence detector.
interface seq_detect_prog_if
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               inp_bit;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, inp_bit,
        input  seq_seen, match_count, cfg_err, armed
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, inp_bit,
        output seq_seen, match_count, cfg_err, armed
    );

endinterface

// File: rtl/seq_detect_prog_hist_shift.sv
// Shift history of received bits (newest in bit 0) plus a fill counter saturating at MAX_LEN.
module seq_hist_shift
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               shift,
    input  logic               shift_bit,
    output logic [MAX_LEN-1:0] history,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    // Clearing wins over shifting: a non-overlapping match restarts the fill from zero.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= {history[MAX_LEN-2:0], shift_bit};
            if (fill != FILL_MAX) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector; match counter compiled in only with SEQ_DETECT_PROG_COUNT_EN.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic               clk,
    input logic               reset,
    seq_detect_prog_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t             state;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               seq_q;
    logic               err_q;
    logic               armed_q;

    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] candidate;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic               cfg_ok;
    logic               shift;
    logic               clr;
    logic               match;

    assign cfg_ok = (bus.cfg_len >= LEN_MIN) && (bus.cfg_len <= LEN_MAX);
    assign shift  = bus.in_valid && (state == ARMED) && !bus.cfg_load;
    assign clr    = bus.cfg_load || (match && !overlap_q);

    // The match looks at the history as it will be once the current bit is shifted in.
    always_comb begin
        candidate = {history[MAX_LEN-2:0], bus.inp_bit};
        fill_next = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        match = shift && (fill_next >= len_q) && (((candidate ^ pattern_q) & mask) == '0);
    end

    seq_hist_shift #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .shift     (shift),
        .shift_bit (bus.inp_bit),
        .history   (history),
        .fill      (fill)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNCFG;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            seq_q     <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else if (bus.cfg_load) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= bus.cfg_len;
            overlap_q <= bus.cfg_overlap;
            seq_q     <= 1'b0;
            state     <= cfg_ok ? ARMED : ERR;
            armed_q   <= cfg_ok;
            err_q     <= !cfg_ok;
        end else begin
            seq_q <= match;
        end
    end

`ifdef SEQ_DETECT_PROG_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // Saturating: once all ones the counter stays put.
    always_ff @(posedge clk) begin
        if (reset || bus.cfg_load) begin
            count_q <= '0;
        end else if (match && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.match_count = count_q;
`else
    assign bus.match_count = '0;
`endif

    assign bus.seq_seen = seq_q;
    assign bus.cfg_err  = err_q;
    assign bus.armed    = armed_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_prog;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus ();

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Expected match_count depends on whether the counter is compiled in.
    function automatic int cnt(input int n);
`ifdef SEQ_DETECT_PROG_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic applyStimulus(input logic rst, input logic load, input logic [7:0] pat,
                                 input logic [3:0] len, input logic ovl,
                                 input logic valid, input logic b);
        reset           = rst;
        bus.cfg_load    = load;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.in_valid    = valid;
        bus.inp_bit     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        applyStimulus(1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0);
    endtask

    task automatic sendBit(input logic b);
        applyStimulus(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] bits7;
        logic [6:0] exp7;
        logic [3:0] exp4;

        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_armed", 32'(bus.armed), 0);
        checkOutput("rst_err",   32'(bus.cfg_err), 0);
        checkOutput("rst_seen",  32'(bus.seq_seen), 0);
        checkOutput("rst_count", 32'(bus.match_count), 0);
        idle();

        // Pattern 1011 overlapping, stream 1011011: hits after bits 4 and 7.
        loadCfg(8'b0000_1011, 4'd4, 1'b1);
        checkOutput("t1_armed", 32'(bus.armed), 1);
        checkOutput("t1_err",   32'(bus.cfg_err), 0);
        bits7 = 7'b1011011;
        exp7  = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            sendBit(bits7[i]);
            checkOutput($sformatf("t1_seen_b%0d", 7 - i), 32'(bus.seq_seen), 32'(exp7[i]));
        end
        checkOutput("t1_count", 32'(bus.match_count), 32'(cnt(2)));
        idle();
        checkOutput("t1_idle_seen", 32'(bus.seq_seen), 0);
        checkOutput("t1_idle_count", 32'(bus.match_count), 32'(cnt(2)));

        // Pattern 11 overlapping on 1111: three hits.
        loadCfg(8'b0000_0011, 4'd2, 1'b1);
        checkOutput("t2o_clr_count", 32'(bus.match_count), 0);
        exp4 = 4'b0111;
        for (int i = 3; i >= 0; i--) begin
            sendBit(1'b1);
            checkOutput($sformatf("t2o_seen_b%0d", 4 - i), 32'(bus.seq_seen), 32'(exp4[i]));
        end
        checkOutput("t2o_count", 32'(bus.match_count), 32'(cnt(3)));

        // Same pattern non-overlapping: two hits.
        loadCfg(8'b0000_0011, 4'd2, 1'b0);
        exp4 = 4'b0101;
        for (int i = 3; i >= 0; i--) begin
            sendBit(1'b1);
            checkOutput($sformatf("t2n_seen_b%0d", 4 - i), 32'(bus.seq_seen), 32'(exp4[i]));
        end
        checkOutput("t2n_count", 32'(bus.match_count), 32'(cnt(2)));

        // Invalid lengths 0 and 9 go to ERR and ignore data.
        loadCfg(8'b0000_0011, 4'd0, 1'b1);
        checkOutput("t3_len0_err",   32'(bus.cfg_err), 1);
        checkOutput("t3_len0_armed", 32'(bus.armed), 0);
        for (int i = 0; i < 3; i++) begin
            sendBit(1'b1);
            checkOutput($sformatf("t3_len0_seen_%0d", i), 32'(bus.seq_seen), 0);
        end
        loadCfg(8'b0000_0011, 4'd9, 1'b1);
        checkOutput("t3_len9_err",   32'(bus.cfg_err), 1);
        checkOutput("t3_len9_armed", 32'(bus.armed), 0);
        for (int i = 0; i < 3; i++) begin
            sendBit(1'b1);
            checkOutput($sformatf("t3_len9_seen_%0d", i), 32'(bus.seq_seen), 0);
        end
        checkOutput("t3_len9_count", 32'(bus.match_count), 0);
        loadCfg(8'b0000_0011, 4'd2, 1'b1);
        checkOutput("t3_reload_armed", 32'(bus.armed), 1);
        checkOutput("t3_reload_err",   32'(bus.cfg_err), 0);

        // A bit presented together with cfg_load is dropped.
        applyStimulus(1'b0, 1'b1, 8'b0000_0011, 4'd2, 1'b1, 1'b1, 1'b1);
        sendBit(1'b1);
        checkOutput("t3b_drop_seen", 32'(bus.seq_seen), 0);
        sendBit(1'b1);
        checkOutput("t3b_next_seen", 32'(bus.seq_seen), 1);

        // 1011 with idle gaps between bits: one hit, quiet during gaps.
        loadCfg(8'b0000_1011, 4'd4, 1'b1);
        bits7 = 7'b1011000;
        exp7  = 7'b0001000;
        for (int i = 6; i >= 3; i--) begin
            sendBit(bits7[i]);
            checkOutput($sformatf("t4_seen_b%0d", 7 - i), 32'(bus.seq_seen), 32'(exp7[i]));
            idle();
            checkOutput($sformatf("t4_gap_seen_%0d", 7 - i), 32'(bus.seq_seen), 0);
        end
        checkOutput("t4_count", 32'(bus.match_count), 32'(cnt(1)));

        // Six ones on pattern 11 overlapping: five hits, counter holds at 3.
        loadCfg(8'b0000_0011, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) sendBit(1'b1);
        checkOutput("t5_sat_seen",  32'(bus.seq_seen), 1);
        checkOutput("t5_sat_count", 32'(bus.match_count), 32'(cnt(3)));

        // Reset after three bits of 1011 (with a coincident load) discards the partial match.
        loadCfg(8'b0000_1011, 4'd4, 1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        applyStimulus(1'b1, 1'b1, 8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1);
        checkOutput("t6_rst_armed", 32'(bus.armed), 0);
        checkOutput("t6_rst_count", 32'(bus.match_count), 0);
        sendBit(1'b1);
        checkOutput("t6_uncfg_seen", 32'(bus.seq_seen), 0);
        loadCfg(8'b0000_1011, 4'd4, 1'b1);
        sendBit(1'b1);
        checkOutput("t6_rearm_seen", 32'(bus.seq_seen), 0);
        checkOutput("t6_rearm_armed", 32'(bus.armed), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
